// File: rtl/z_core_div_pkg.sv
// Shared core constants for the RV32M divide path: operand width, divide op
// codes (funct3[1:0]) and the divider FSM state encoding.
package z_core_div_pkg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_t;
endpackage

// File: rtl/z_core_div_step.sv
// One combinational restoring radix-2 division iteration over {rem,quo}.
module z_core_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // The shifted remainder can reach 2*dvsr-1, so the trial subtract needs one extra bit.
  assign rem_sh = {rem_in, quo_in[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvsr};

  always_comb begin
    rem_out = rem_sh[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      rem_out    = diff[XLEN-1:0];
      quo_out[0] = 1'b1;
    end
  end
endmodule

// File: rtl/z_core_div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): PREP, XLEN restoring steps,
// sign fixup, then holds the result until the consumer takes it.
module z_core_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  import z_core_div_pkg::*;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state;
  logic [1:0]       op_q;
  logic [XLEN-1:0]  a_q, b_q;
  logic [XLEN-1:0]  rem_q, quo_q, dvsr_q;
  logic [CNT_W-1:0] cnt;
  logic             sign_q, sign_r;

  logic [XLEN-1:0]  rem_nx, quo_nx;
  logic             is_signed, a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;

  // Magnitudes of INT_MIN stay 0x80.. and are then treated as unsigned.
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & a_q[XLEN-1];
  assign b_neg     = is_signed & b_q[XLEN-1];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;

  z_core_div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvsr    (dvsr_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_q     <= div_op;
          a_q      <= dividend;
          b_q      <= divisor;
          state    <= S_PREP;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        S_PREP: begin
          if (b_q == '0) begin
            result    <= op_q[1] ? a_q : '1;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (is_signed && a_q == INT_MIN && b_q == '1) begin
            result    <= op_q[1] ? '0 : INT_MIN;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            rem_q  <= '0;
            quo_q  <= a_mag;
            dvsr_q <= b_mag;
            sign_q <= a_neg ^ b_neg;
            sign_r <= a_neg;
            cnt    <= '0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN-1)) state <= S_FIX;
        end
        S_FIX: begin
          if (op_q[1]) result <= sign_r ? -rem_q : rem_q;
          else         result <= sign_q ? -quo_q : quo_q;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_z_core_div_unit.sv
// Directed-vector bench for z_core_div_unit: results, latency, backpressure, flush, reset.
module tb_z_core_div_unit;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]  div_op;
  logic [31:0] dividend, divisor, result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  z_core_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .div_op(div_op),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a request for exactly one edge; caller sits #1 after an edge.
  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    div_op = op; dividend = a; divisor = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; dividend = '0; divisor = '0;
  endtask

  // Latency counts the accept edge as 1; in_ready must stay low while waiting.
  task automatic wait_valid(output int lat, output logic ir_ok);
    lat = 1; ir_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) ir_ok = 1'b0;
      tick();
      lat++;
    end
    if (in_ready) ir_ok = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic ir_ok;
    accept(op, a, b);
    wait_valid(lat, ir_ok);
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " res"}, result, exp);
    chk({tag, " in_ready low"}, {31'b0, ir_ok}, 32'd1);
    consume();
    chk({tag, " idle in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, " idle out_valid"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int       lat;
    logic     ir_ok, stable;
    logic [31:0] held;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    div_op = '0; dividend = '0; divisor = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst result", result, 32'h0);

    run("div 20/-3", 2'b00, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 35);
    run("rem 20/-3", 2'b10, 32'd20, 32'hFFFF_FFFD, 32'h0000_0002, 35);
    run("divu ff/10", 2'b01, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 35);
    run("remu ff/10", 2'b11, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 35);
    run("div 7/0", 2'b00, 32'd7, 32'd0, 32'hFFFF_FFFF, 2);
    run("remu 7/0", 2'b11, 32'd7, 32'd0, 32'h0000_0007, 2);
    run("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
    run("divu ovf ops", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 35);
    run("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    run("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);

    // Backpressure: result and in_ready frozen while out_ready is low.
    accept(2'b00, 32'd1000, 32'd9);
    wait_valid(lat, ir_ok);
    chk("bp lat", lat, 35);
    held = result; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    chk("bp hold", {31'b0, stable}, 32'd1);
    chk("bp res", result, 32'd111);
    consume();
    chk("bp release in_ready", {31'b0, in_ready}, 32'd1);

    // Flush in IDLE with a pending request: not taken.
    in_valid = 1'b1; div_op = 2'b00; dividend = 32'd5; divisor = 32'd1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("idle flush in_ready", {31'b0, in_ready}, 32'd1);
    chk("idle flush busy", {31'b0, busy}, 32'd0);

    // Flush mid-calculation at accept+10.
    accept(2'b00, 32'd50, 32'd3);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush in_ready", {31'b0, in_ready}, 32'd1);
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    stable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid !== 1'b0) stable = 1'b0;
    end
    chk("flush no result", {31'b0, stable}, 32'd1);

    // Reset at accept+5 of a second request.
    accept(2'b01, 32'd77, 32'd4);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid rst result", result, 32'h0);

    // Flush while a result waits in DONE, with out_ready high: discarded.
    accept(2'b01, 32'd9, 32'd0);
    wait_valid(lat, ir_ok);
    chk("done flush lat", lat, 2);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("done flush out_valid", {31'b0, out_valid}, 32'd0);
    chk("done flush in_ready", {31'b0, in_ready}, 32'd1);

    run("div 100/7", 2'b00, 32'd100, 32'd7, 32'h0000_000E, 35);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/z_core_div_unit.md
Name: z_core_div_unit

Overview:
- Multi-cycle RV32M divider (DIV, DIVU, REM, REMU). It is the sequential companion to the combinational execute ALU.
- It consumes the same execute-stage operands (rs1/rs2 values) that the ALU receives.
- Its result is merged into the execute result path downstream of the ALU output mux.
- The core stalls on in_ready/out_valid while a division is in flight.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  pipeline kill; aborts any operation in flight.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (equals funct3[1:0]).
- dividend  input  XLEN  rs1 value.
- divisor  input  XLEN  rs2 value.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  quotient or remainder.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; counter=0.
  - Reset has priority over flush and over any handshake.
- Handshake:
  - A request is accepted on a rising edge where in_valid & in_ready. Operands and div_op are latched at that edge.
  - in_ready = (state==IDLE). Inputs are ignored in every other state.
  - The result is consumed on a rising edge where out_valid & out_ready. The unit then returns to IDLE.
  - There is no back-to-back overlap: the next request is accepted no earlier than the cycle after consumption.
- States:
  - IDLE -> PREP on accept.
  - PREP (1 cycle):
    - For signed ops, take absolute values and record sign_q = sign(dividend)^sign(divisor) and sign_r = sign(dividend).
    - Detect special cases. If one applies -> DONE with the special result; otherwise -> CALC with counter=0.
  - CALC (exactly XLEN cycles): one restoring radix-2 step per cycle.
    - Shift {rem,quo} left by 1.
    - Trial-subtract |divisor| using an XLEN+1-bit subtract.
    - If non-negative, keep the difference and set the quotient LSB.
    - Increment counter; -> FIX when counter==XLEN-1.
  - FIX (1 cycle):
    - Apply signs: quotient negated if sign_q; remainder negated if sign_r.
    - Select quotient (div_op[1]=0) or remainder (div_op[1]=1) into result.
    - -> DONE.
  - DONE: out_valid=1 and result is stable. -> IDLE on out_ready.
- Latency from the accept edge T:
  - Normal: out_valid first high in cycle T+35 (PREP T+1, CALC T+2..T+33, FIX T+34).
  - Special cases: out_valid first high in cycle T+2.
- Special cases (RISC-V spec, no trap):
  - Divisor=0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend.
  - Signed overflow (dividend=0x80000000, divisor=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
  - Unsigned ops with divisor=0xFFFFFFFF are not special and take the normal path.
- Abs of 0x80000000 is 0x80000000, treated as unsigned magnitude. The quotient/remainder datapath is unsigned XLEN.
- Flush:
  - In any state, next state=IDLE and out_valid=0 at the next edge.
  - A result already in DONE is discarded.
  - Flush in IDLE with in_valid high: the request is not accepted, and in_ready stays 1.
- out_valid and out_ready together with flush in the same cycle: flush wins; treat as discarded.
- result holds its last value in IDLE and is only meaningful while out_valid=1.

Decomposition:
- Shared core package: div op constants (DIV_OP_DIV=2'b00, DIV_OP_DIVU=2'b01, DIV_OP_REM=2'b10, DIV_OP_REMU=2'b11) and FSM state encodings.
- The package also holds XLEN, so the decoder and this unit share them.
- One natural sub-module: z_core_div_step. It is a combinational single restoring iteration: inputs {rem,quo}, divisor; outputs next {rem,quo}.
- The FSM, sign handling and special-case detection stay in z_core_div_unit.

Test Plan:
- DIV 20 / -3 -> result 0xFFFFFFFA (-6), out_valid first at accept+35; REM same operands -> 0x00000002.
- DIVU 0xFFFFFFFF / 0x00000010 -> 0x0FFFFFFF; REMU -> 0x0000000F; in_ready=0 throughout.
- Divide by zero: DIV 7/0 -> 0xFFFFFFFF and REMU 7/0 -> 0x00000007, both at accept+2.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0x00000000; DIVU on the same operands -> 0x00000000 via the normal 35-cycle path.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid; result stays stable and in_ready=0. Raising out_ready gives in_ready=1 the next cycle.
- Flush at accept+10, then rst at accept+5 of a second request: in_ready=1 and out_valid=0 on the following edge. A new DIV 100/7 then returns 0x0000000E.
